// File: rtl/booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator
//   Sits downstream of the 3x3 signed Booth multiplier. Takes one signed
//   product per input handshake and adds N_TERMS of them into a saturating
//   signed sum (one dot-product frame). The frame result is then held on a
//   valid/ready output port until downstream takes it.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous abort: drops the partial frame and any held result
//   i_in_valid   i_in_prod is valid this cycle
//   o_in_ready   a product can be accepted this cycle (ACCUM state)
//   i_in_prod    signed product, PROD_W bits
//   o_out_valid  o_out_sum / o_out_ovf hold a completed frame (HOLD state)
//   i_out_ready  downstream takes the frame this cycle
//   o_out_sum    saturated frame sum, ACC_W bits signed
//   o_out_ovf    saturation happened at least once during the frame
// ---------------------------------------------------------------------------
module booth_product_accumulator #(
   parameter int PROD_W  = 6,
   parameter int ACC_W   = 12,
   parameter int N_TERMS = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_clr,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic signed [PROD_W-1:0] i_in_prod,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic signed [ACC_W-1:0]  o_out_sum,
   output logic                     o_out_ovf
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ovf;

   logic                     w_accept;
   logic                     w_last;
   logic [ACC_W:0]           w_wide;
   logic                     w_clamped;
   logic signed [ACC_W-1:0]  w_nxt;

   assign w_accept = i_in_valid & o_in_ready;
   assign w_last   = (r_cnt == LAST_CNT);

   // One guard bit: sign-extend both operands to ACC_W+1 bits. The sum left
   // the ACC_W range exactly when the guard bit disagrees with the ACC_W sign.
   assign w_wide    = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-PROD_W){i_in_prod[PROD_W-1]}}, i_in_prod};
   assign w_clamped = w_wide[ACC_W] ^ w_wide[ACC_W-1];

   always_comb begin
      w_nxt = w_wide[ACC_W-1:0];
      if (w_clamped) w_nxt = w_wide[ACC_W] ? SAT_MIN : SAT_MAX;
   end

   // ---- FSM: state register ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ACCUM;
      else          r_state <= w_state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_state_nxt = r_state;
      if (i_clr) begin
         w_state_nxt = ACCUM;
      end else begin
         case (r_state)
            ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
            HOLD:    if (i_out_ready)        w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
         endcase
      end
   end

   // ---- FSM: outputs ----
   // HOLD->ACCUM has no bypass: in_ready only follows the registered state.
   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         ACCUM:   o_in_ready  = 1'b1;
         HOLD:    o_out_valid = 1'b1;
         default: o_in_ready  = 1'b1;
      endcase
   end

   // ---- Datapath ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         o_out_sum <= '0;
         o_out_ovf <= 1'b0;
      end else if (i_clr) begin
         // Abort wins over a same-cycle accept or output handshake.
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         o_out_sum <= '0;
         o_out_ovf <= 1'b0;
      end else if (w_accept) begin
         if (w_last) begin
            o_out_sum <= w_nxt;
            o_out_ovf <= r_ovf | w_clamped;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
         end else begin
            r_acc     <= w_nxt;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_ovf     <= r_ovf | w_clamped;
         end
      end
   end

endmodule
